pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush controller for the 5-stage pipeline. Drives the enable, flush and bubble controls
//  of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three hazard sources:
//  - data-memory wait states;
//  - taken branches resolved in EX;
//  - load-use dependencies between ID and EX.
//  Also keeps a memory-wait FSM with a timeout watchdog, plus saturating stall and flush counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles on one MEM access before error (>=2)
//  CNT_W        32  width of the stall_cycles and flush_events counters
// PORTS
//  clk           in   1      pipeline clock
//  reset         in   1      asynchronous, active-high reset
//  id_rs         in   5      rs field of the instruction in ID
//  id_rt         in   5      rt field of the instruction in ID
//  id_uses_rt    in   1      the ID instruction reads rt as a source
//  ex_memread    in   1      the EX instruction is a load
//  ex_rt_dest    in   5      destination register of the EX load
//  ex_br_taken   in   1      branch in EX resolved taken
//  mem_req       in   1      MEM stage is performing a load or store
//  dmem_ready    in   1      data memory completes the access this cycle
//  pc_en         out  1      PC may update
//  ifid_en       out  1      IF/ID load enable
//  ifid_flush    out  1      IF/ID clear to NOP
//  idex_en       out  1      ID/EX load enable
//  idex_flush    out  1      ID/EX clear to NOP; control bits zeroed
//  exmem_en      out  1      EX/MEM load enable
//  memwb_bubble  out  1      MEM/WB captures RegWrite=0, MemtoReg=0; it is always clocked
//  mem_error     out  1      sticky flag: MEM access exceeded MEM_TIMEOUT
//  stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 in RUN or WAIT
//  flush_events  out  CNT_W  saturating count of cycles with ifid_flush=1
// BEHAVIOUR
//  FSM states: RUN, WAIT, ERR; the state is registered. All control outputs are combinational from the state and inputs.
//  mem_stall = mem_req & ~dmem_ready.
//  load_use  = ex_memread & (ex_rt_dest!=0) & ((ex_rt_dest==id_rs) | (id_uses_rt & (ex_rt_dest==id_rt))).
//  Priority is ERR > mem_stall > ex_br_taken > load_use > normal.
//  - mem_stall: pc_en=ifid_en=idex_en=exmem_en=0; memwb_bubble=1; no flush. A pending branch or load-use waits,
//    because EX is frozen and re-presents it once dmem_ready arrives.
//  - ex_br_taken: pc_en=1 (PC takes the target); ifid_flush=idex_flush=1; all enables=1. load_use is ignored
//    because the ID instruction is on the wrong path.
//  - load_use: pc_en=ifid_en=0; idex_flush=1; exmem_en=1. Exactly one bubble; the next cycle has ex_memread=0.
//  - normal: all enables=1; all flush and bubble outputs=0.
//  FSM transitions:
//  - RUN->WAIT when mem_stall; wait_cnt loads 1.
//  - WAIT->RUN when dmem_ready. That is the completion cycle: mem_stall=0, so the pipeline advances.
//  - WAIT: wait_cnt increments each stalled cycle. WAIT->ERR when wait_cnt==MEM_TIMEOUT and still mem_stall.
//  - ERR: all enables=0; memwb_bubble=1; flushes=0; mem_error=1. ERR is held until reset.
//  - mem_req dropping in WAIT (squashed request) returns to RUN with no error.
//  Counters: stall_cycles increments on cycles with pc_en=0 outside ERR. flush_events increments on cycles with
//  ifid_flush=1. Both hold at all-ones and never wrap.
//  Reset (async, mid-access included): state=RUN, wait_cnt=0, mem_error=0, counters=0. While reset=1 every enable
//  is 0 and memwb_bubble=1. After release the block starts in RUN and ignores any access that was in flight.
// STRUCTURE
//  Package pipe_ctrl_pkg holds: the state enum {RUN, WAIT, ERR}; localparam REG_ZERO=5'd0; the wait counter width
//  $clog2(MEM_TIMEOUT+1).
//  One sub-module, sat_counter #(W) (clk, reset, inc, count), is instantiated twice for the two event counters.
// TESTING
//  1. Load r5 in EX with id_rs=5: one cycle pc_en=0, idex_flush=1; next cycle all enables=1; stall_cycles=1.
//  2. Load with ex_rt_dest=0 and id_rs=0: no stall.
//  3. id_rt=5 with id_uses_rt=0: no stall.
//  4. ex_br_taken=1 together with a load_use match: ifid_flush=idex_flush=1, pc_en=1; flush_events=1, stall_cycles=0.
//  5. mem_req=1 with dmem_ready low for 3 cycles: 3 frozen cycles with memwb_bubble=1. On the 4th cycle dmem_ready=1:
//     all enables=1, state=RUN, stall_cycles=3.
//  6. mem_req held with dmem_ready=0 for MEM_TIMEOUT+1 cycles: mem_error=1, all enables stay 0.
//     Assert reset mid-ERR: every output returns to its reset value immediately, without a clock edge.
//  7. Force 2^CNT_W-1 stalls (CNT_W=4 build): stall_cycles holds at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    // Memory-wait FSM states
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_e;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Width of the wait counter, large enough to hold the timeout value itself
    function automatic int wait_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, never wraps.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register with async clear and saturation at the maximum value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= {W{1'b0}};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: resolves memory
// wait states, taken branches and load-use hazards into per-stage enable,
// flush and bubble controls, with a memory-timeout watchdog and event counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt_dest,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCW = wait_cnt_w(MEM_TIMEOUT);
    localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

    state_e         r_state;
    state_e         w_next_state;
    logic [WCW-1:0] r_wait_cnt;
    logic [WCW-1:0] w_next_wait_cnt;

    logic w_mem_stall;
    logic w_load_use;
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_mem_stall = mem_req & ~dmem_ready;
    assign w_load_use  = ex_memread & (ex_rt_dest != REG_ZERO) &
                         ((ex_rt_dest == id_rs) | (id_uses_rt & (ex_rt_dest == id_rt)));

    // FSM state and wait-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= {WCW{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
        end
    end

    // Next-state logic: track one MEM access and trap if it never completes
    always_comb begin
        w_next_state    = r_state;
        w_next_wait_cnt = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_next_state    = WAIT;
                    w_next_wait_cnt = WCW'(1);
                end else begin
                    w_next_state    = RUN;
                    w_next_wait_cnt = {WCW{1'b0}};
                end
            end
            WAIT: begin
                if (!mem_req) begin
                    // request squashed upstream: drop it without error
                    w_next_state    = RUN;
                    w_next_wait_cnt = {WCW{1'b0}};
                end else if (dmem_ready) begin
                    w_next_state    = RUN;
                    w_next_wait_cnt = {WCW{1'b0}};
                end else if (r_wait_cnt == TIMEOUT_VAL) begin
                    w_next_state    = ERR;
                    w_next_wait_cnt = r_wait_cnt;
                end else begin
                    w_next_state    = WAIT;
                    w_next_wait_cnt = r_wait_cnt + WCW'(1);
                end
            end
            ERR: begin
                // only reset leaves the error state
                w_next_state    = ERR;
                w_next_wait_cnt = r_wait_cnt;
            end
            default: begin
                w_next_state    = RUN;
                w_next_wait_cnt = {WCW{1'b0}};
            end
        endcase
    end

    // Pipeline control outputs by priority: reset > ERR > mem stall > branch > load-use > normal
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        mem_error    = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (r_state == ERR) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            mem_error    = 1'b1;
        end else if (w_mem_stall) begin
            // freeze everything up to MEM; EX re-presents any pending branch/load later
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_br_taken) begin
            // ID and IF hold wrong-path instructions, so any load-use there is moot
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_load_use) begin
            // hold PC and IF/ID, inject one NOP into ID/EX
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
        end else begin
            pc_en        = 1'b1;
        end
    end

    assign w_stall_inc = ~pc_en & ~reset & (r_state != ERR);
    assign w_flush_inc = ifid_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (CNT_W=4 build).
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 4;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_error}
    localparam logic [7:0] V_NORMAL = 8'b1101_0100;
    localparam logic [7:0] V_BRANCH = 8'b1111_1100;
    localparam logic [7:0] V_LDUSE  = 8'b0001_1100;
    localparam logic [7:0] V_MSTALL = 8'b0000_0010;
    localparam logic [7:0] V_ERR    = 8'b0000_0011;
    localparam logic [7:0] V_RESET  = 8'b0000_0010;

    logic             clk;
    logic             reset;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt_dest;
    logic             ex_br_taken;
    logic             mem_req;
    logic             dmem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;
    logic [7:0]       ctrl;

    int n_cmp;
    int n_err;

    assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_error};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_memread   (ex_memread),
        .ex_rt_dest   (ex_rt_dest),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_bubble (memwb_bubble),
        .mem_error    (mem_error),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs       = 5'd0;
        id_rt       = 5'd0;
        id_uses_rt  = 1'b0;
        ex_memread  = 1'b0;
        ex_rt_dest  = 5'd0;
        ex_br_taken = 1'b0;
        mem_req     = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check_val("rst_ctrl", {24'd0, ctrl}, {24'd0, V_RESET});
        check_val("rst_stall", {28'd0, stall_cycles}, 32'd0);
        check_val("rst_flush", {28'd0, flush_events}, 32'd0);
        tick();
        clear_inputs();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        do_reset();
        check_val("idle_ctrl", {24'd0, ctrl}, {24'd0, V_NORMAL});

        // 1: load-use on rs -> one bubble
        ex_memread = 1'b1; ex_rt_dest = 5'd5; id_rs = 5'd5; #1;
        check_val("t1_lduse", {24'd0, ctrl}, {24'd0, V_LDUSE});
        tick();
        ex_memread = 1'b0; #1;
        check_val("t1_after", {24'd0, ctrl}, {24'd0, V_NORMAL});
        check_val("t1_stall", {28'd0, stall_cycles}, 32'd1);

        // 2: load to r0 never stalls
        ex_memread = 1'b1; ex_rt_dest = 5'd0; id_rs = 5'd0; #1;
        check_val("t2_r0", {24'd0, ctrl}, {24'd0, V_NORMAL});

        // 3: rt match only matters when rt is a source
        ex_rt_dest = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0; #1;
        check_val("t3_rt_unused", {24'd0, ctrl}, {24'd0, V_NORMAL});
        id_uses_rt = 1'b1; #1;
        check_val("t3_rt_used", {24'd0, ctrl}, {24'd0, V_LDUSE});
        tick();
        clear_inputs(); #1;
        check_val("t3_stall", {28'd0, stall_cycles}, 32'd2);

        // 4: branch beats load-use
        do_reset();
        ex_memread = 1'b1; ex_rt_dest = 5'd7; id_rs = 5'd7; ex_br_taken = 1'b1; #1;
        check_val("t4_branch", {24'd0, ctrl}, {24'd0, V_BRANCH});
        tick();
        clear_inputs(); #1;
        check_val("t4_flush", {28'd0, flush_events}, 32'd1);
        check_val("t4_stall", {28'd0, stall_cycles}, 32'd0);

        // 5: three wait cycles, branch pending is held off, then completion
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0; ex_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val($sformatf("t5_wait%0d", i), {24'd0, ctrl}, {24'd0, V_MSTALL});
            tick();
        end
        dmem_ready = 1'b1; ex_br_taken = 1'b0; #1;
        check_val("t5_done", {24'd0, ctrl}, {24'd0, V_NORMAL});
        check_val("t5_stall", {28'd0, stall_cycles}, 32'd3);
        check_val("t5_noflush", {28'd0, flush_events}, 32'd0);
        tick();
        mem_req = 1'b0; dmem_ready = 1'b0; #1;
        check_val("t5_run", {24'd0, ctrl}, {24'd0, V_NORMAL});

        // squashed request: mem_req drops in WAIT, no error
        mem_req = 1'b1;
        tick();
        tick();
        mem_req = 1'b0; #1;
        check_val("sq_ctrl", {24'd0, ctrl}, {24'd0, V_NORMAL});
        tick();
        check_val("sq_noerr", {24'd0, ctrl}, {24'd0, V_NORMAL});

        // 6/7: timeout -> ERR; stall counter saturates at 15 on the way
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
            #1;
            if (i == MEM_TIMEOUT) begin
                check_val("t6_last_wait", {24'd0, ctrl}, {24'd0, V_MSTALL});
            end
            tick();
        end
        check_val("t6_err", {24'd0, ctrl}, {24'd0, V_ERR});
        check_val("t7_stall_sat", {28'd0, stall_cycles}, 32'd15);
        dmem_ready = 1'b1; ex_br_taken = 1'b1;
        tick();
        check_val("t6_err_sticky", {24'd0, ctrl}, {24'd0, V_ERR});
        check_val("t6_err_noflush", {28'd0, flush_events}, 32'd0);
        reset = 1'b1; #1;
        check_val("t6_async_ctrl", {24'd0, ctrl}, {24'd0, V_RESET});
        check_val("t6_async_stall", {28'd0, stall_cycles}, 32'd0);
        tick();
        clear_inputs();
        reset = 1'b0; #1;
        check_val("t6_run_again", {24'd0, ctrl}, {24'd0, V_NORMAL});

        // 7: repeated load-use and branch cycles saturate both counters
        ex_memread = 1'b1; ex_rt_dest = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 20; i++) tick();
        check_val("t7_ld_sat", {28'd0, stall_cycles}, 32'd15);
        ex_br_taken = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check_val("t7_fl_sat", {28'd0, flush_events}, 32'd15);
        check_val("t7_st_hold", {28'd0, stall_cycles}, 32'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
